// File: rtl/rca_pkg.sv
// Shared constants and helpers for the segmented ripple-carry adder pipeline.
package rca_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int nseg(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple of full-adder cells; exposes the carry into the
// top bit so the caller can derive signed overflow.
module rca_seg
  import rca_pkg::*;
#(
  parameter int SEG = DEF_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb_in
);

  logic [SEG:0] carry_s;

  // Full-adder chain, LSB first.
  always_comb begin
    carry_s    = {(SEG+1){1'b0}};
    sum        = {SEG{1'b0}};
    carry_s[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = carry_s[SEG];
  assign c_msb_in = carry_s[SEG-1];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: each stage resolves one SEG-bit
// segment and hands its carry plus the still-pending operand bits downstream.
module rca_pipe
  import rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSEG = nseg(WIDTH, SEG);

  if (WIDTH % SEG != 0) begin : g_bad_cfg
    $error("rca_pipe: WIDTH must be a multiple of SEG");
  end

  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;
  logic [NSEG-1:0]  valid_s;
  logic [NSEG:0]    rdy_s;

  // Subtraction is A + ~B + 1; the external carry-in only matters for add.
  always_comb begin
    if (in_sub == OP_SUB) begin
      b_eff_s = ~in_b;
      c0_s    = 1'b1;
    end else begin
      b_eff_s = in_b;
      c0_s    = in_cin;
    end
  end

  // Ready ripples back from the sink; an empty stage always accepts.
  always_comb begin
    rdy_s       = {(NSEG+1){1'b0}};
    rdy_s[NSEG] = out_ready;
    for (int i = NSEG - 1; i >= 0; i--) begin
      rdy_s[i] = !valid_s[i] || rdy_s[i+1];
    end
  end

  genvar k;
  for (k = 0; k < NSEG; k++) begin : g_stg
    localparam int HI = (k + 1) * SEG;

    logic          valid_r;
    logic          carry_r;
    logic [HI-1:0] sum_r;
    logic [HI-1:0] sum_nxt_s;
    logic          up_valid_s;
    logic [SEG-1:0] seg_a_s;
    logic [SEG-1:0] seg_b_s;
    logic [SEG-1:0] seg_sum_s;
    logic          seg_cin_s;
    logic          seg_cout_s;
    logic          seg_cmsb_s;

    if (k == 0) begin : g_src
      assign up_valid_s = in_valid;
      assign seg_a_s    = in_a[SEG-1:0];
      assign seg_b_s    = b_eff_s[SEG-1:0];
      assign seg_cin_s  = c0_s;
      assign sum_nxt_s  = seg_sum_s;
    end else begin : g_src
      assign up_valid_s = g_stg[k-1].valid_r;
      assign seg_a_s    = g_stg[k-1].g_fwd.a_r[SEG-1:0];
      assign seg_b_s    = g_stg[k-1].g_fwd.b_r[SEG-1:0];
      assign seg_cin_s  = g_stg[k-1].carry_r;
      assign sum_nxt_s  = {seg_sum_s, g_stg[k-1].sum_r};
    end

    rca_seg #(.SEG(SEG)) u_seg (
      .a        (seg_a_s),
      .b        (seg_b_s),
      .cin      (seg_cin_s),
      .sum      (seg_sum_s),
      .cout     (seg_cout_s),
      .c_msb_in (seg_cmsb_s)
    );

    assign valid_s[k] = valid_r;

    // Stage register: advances when downstream can take it; data moves only with a valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
        carry_r <= 1'b0;
        sum_r   <= {HI{1'b0}};
      end else begin
        if (rdy_s[k]) begin
          valid_r <= up_valid_s;
        end
        if (rdy_s[k] && up_valid_s) begin
          carry_r <= seg_cout_s;
          sum_r   <= sum_nxt_s;
        end
      end
    end

    // Operand bits above this segment, delayed to meet their carry.
    if (k < NSEG - 1) begin : g_fwd
      localparam int REM = WIDTH - HI;
      logic [REM-1:0] a_r;
      logic [REM-1:0] b_r;
      logic [REM-1:0] a_nxt_s;
      logic [REM-1:0] b_nxt_s;
      logic           cmsb_unused_s;

      assign cmsb_unused_s = seg_cmsb_s;

      if (k == 0) begin : g_in
        assign a_nxt_s = in_a[WIDTH-1:SEG];
        assign b_nxt_s = b_eff_s[WIDTH-1:SEG];
      end else begin : g_in
        assign a_nxt_s = g_stg[k-1].g_fwd.a_r[REM+SEG-1:SEG];
        assign b_nxt_s = g_stg[k-1].g_fwd.b_r[REM+SEG-1:SEG];
      end

      // Pending-operand register, loaded alongside the stage's carry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= {REM{1'b0}};
          b_r <= {REM{1'b0}};
        end else if (rdy_s[k] && up_valid_s) begin
          a_r <= a_nxt_s;
          b_r <= b_nxt_s;
        end
      end
    end else begin : g_last
      logic ovf_r;

      // Signed overflow: carry into the MSB disagreeing with carry out of it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (rdy_s[k] && up_valid_s) begin
          ovf_r <= seg_cout_s ^ seg_cmsb_s;
        end
      end
    end
  end

  assign in_ready  = rdy_s[0];
  assign out_valid = valid_s[NSEG-1];
  assign out_sum   = g_stg[NSEG-1].sum_r;
  assign out_cout  = g_stg[NSEG-1].carry_r;
  assign out_ovf   = g_stg[NSEG-1].g_last.ovf_r;

endmodule

// File: tb/tb_rca_pipe.sv
// Randomised self-checking bench: a 32/8 pipeline for directed scenarios and
// 16/16 + 16/4 pipelines for the configuration sweep, all against a word-level model.
module tb_rca_pipe;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks;
  int   failures;

  logic        v32, rdy32, cin32, sub32, ov32, ordy32, co32, of32;
  logic [31:0] a32, b32, sum32;

  logic        v16 [2], rdy16 [2], cin16 [2], sub16 [2], ov16 [2], ordy16 [2], co16 [2], of16 [2];
  logic [15:0] a16 [2], b16 [2], sum16 [2];

  exp_t q32 [$];
  exp_t buf16 [2][64];

  rca_pipe #(.WIDTH(32), .SEG(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .in_a(a32), .in_b(b32),
    .in_cin(cin32), .in_sub(sub32), .out_valid(ov32), .out_ready(ordy32),
    .out_sum(sum32), .out_cout(co32), .out_ovf(of32)
  );

  rca_pipe #(.WIDTH(16), .SEG(16)) u_dut16a (
    .clk(clk), .rst_n(rst_n), .in_valid(v16[0]), .in_ready(rdy16[0]), .in_a(a16[0]), .in_b(b16[0]),
    .in_cin(cin16[0]), .in_sub(sub16[0]), .out_valid(ov16[0]), .out_ready(ordy16[0]),
    .out_sum(sum16[0]), .out_cout(co16[0]), .out_ovf(of16[0])
  );

  rca_pipe #(.WIDTH(16), .SEG(4)) u_dut16b (
    .clk(clk), .rst_n(rst_n), .in_valid(v16[1]), .in_ready(rdy16[1]), .in_a(a16[1]), .in_b(b16[1]),
    .in_cin(cin16[1]), .in_sub(sub16[1]), .out_valid(ov16[1]), .out_ready(ordy16[1]),
    .out_sum(sum16[1]), .out_cout(co16[1]), .out_ovf(of16[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word-level reference: plain modular arithmetic and sign-bit rules.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    logic [63:0] mask, t;
    mask = (64'd1 << w) - 64'd1;
    if (sub) begin
      t      = ({32'd0, a} - {32'd0, b}) & mask;
      e.cout = (a >= b);
    end else begin
      t      = {32'd0, a} + {32'd0, b} + {63'd0, cin};
      e.cout = t[w];
      t      = t & mask;
    end
    e.sum = t[31:0];
    e.ovf = (sub ? (a[w-1] != b[w-1]) : (a[w-1] == b[w-1])) && (t[w-1] != a[w-1]);
    e.acc = 0;
    return e;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic rand32();
    v32   = 1'b1;
    a32   = $urandom;
    b32   = $urandom;
    cin32 = 1'($urandom);
    sub32 = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ov32 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov32); end
    checks++; if (sum32 !== 32'd0) begin failures++; $display("FAIL reset_out_sum got=%h exp=0", sum32); end
    checks++; if ({co32, of32} !== 2'b00) begin failures++; $display("FAIL reset_cout_ovf got=%b%b exp=00", co32, of32); end
    checks++; if (rdy32 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", rdy32); end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ov16[d], rdy16[d], sum16[d]} !== {1'b0, 1'b1, 16'd0}) begin
        failures++; $display("FAIL reset_dut16_%0d got v=%b r=%b s=%h exp v=0 r=1 s=0", d, ov16[d], rdy16[d], sum16[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_carry_chain();
    int  acc_c;
    bit  seen;
    v32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; sub32 = 1'b0; ordy32 = 1'b1;
    #1;
    checks++; if (rdy32 !== 1'b1) begin failures++; $display("FAIL carry_first_accept got=%b exp=1", rdy32); end
    acc_c = cyc;
    nxt();
    v32  = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      #1;
      if (ov32 === 1'b1) begin
        seen = 1'b1;
        checks++; if (cyc - acc_c != 4) begin failures++; $display("FAIL carry_latency got=%0d exp=4", cyc - acc_c); end
        checks++; if ({sum32, co32, of32} !== {32'h0000_0000, 1'b1, 1'b0}) begin
          failures++; $display("FAIL carry_result got=%h c=%b o=%b exp=00000000 c=1 o=0", sum32, co32, of32);
        end
      end
      nxt();
    end
    checks++; if (!seen) begin failures++; $display("FAIL carry_timeout got=no_result exp=result"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] es [2];
    logic [1:0]  ef [2];
    int base, ntake;
    es[0] = 32'hFFFF_FFFE; ef[0] = 2'b00;
    es[1] = 32'h8000_0000; ef[1] = 2'b01;
    ntake = 0; base = cyc; ordy32 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin v32 = 1'b1; a32 = 32'd5; b32 = 32'd7; cin32 = 1'b1; sub32 = 1'b1; end
      else if (i == 1) begin v32 = 1'b1; a32 = 32'h7FFF_FFFF; b32 = 32'd1; cin32 = 1'b0; sub32 = 1'b0; end
      else v32 = 1'b0;
      #1;
      if (i == 0) base = cyc;
      if (ov32 && ordy32 && ntake < 2) begin
        checks++; if (cyc != base + 4 + ntake) begin failures++; $display("FAIL b2b_cycle_%0d got=%0d exp=%0d", ntake, cyc - base, 4 + ntake); end
        checks++; if ({sum32, co32, of32} !== {es[ntake], ef[ntake]}) begin
          failures++; $display("FAIL b2b_result_%0d got=%h c=%b o=%b exp=%h co=%b", ntake, sum32, co32, of32, es[ntake], ef[ntake]);
        end
        ntake++;
      end
      nxt();
    end
    checks++; if (ntake != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", ntake); end
  endtask

  task automatic test_streaming();
    exp_t e;
    int   ntake;
    ntake = 0; ordy32 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) rand32(); else v32 = 1'b0;
      #1;
      if (i < 8) begin
        checks++; if (rdy32 !== 1'b1) begin failures++; $display("FAIL stream_in_ready got=%b exp=1", rdy32); end
      end
      if (ov32 && ordy32) begin
        checks++;
        if (q32.size() == 0) begin failures++; $display("FAIL stream_spurious got=%h exp=none", sum32); end
        else begin
          e = q32.pop_front();
          ntake++;
          if ({sum32, co32, of32} !== {e.sum, e.cout, e.ovf} || cyc - e.acc != 4) begin
            failures++; $display("FAIL stream_result got=%h c=%b o=%b lat=%0d exp=%h c=%b o=%b lat=4",
                                 sum32, co32, of32, cyc - e.acc, e.sum, e.cout, e.ovf);
          end
        end
      end
      if (v32 && rdy32) begin e = model(32, a32, b32, cin32, sub32); e.acc = cyc; q32.push_back(e); end
      nxt();
    end
    checks++; if (ntake != 8 || q32.size() != 0) begin failures++; $display("FAIL stream_count got=%0d exp=8", ntake); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   sent, ntake, occ;
    bit   hold_beat, stalled, saw_full;
    logic [34:0] held;
    sent = 0; ntake = 0; occ = 0; hold_beat = 1'b0; stalled = 1'b0; saw_full = 1'b0; held = '0;
    q32.delete();
    for (int i = 0; i < 40; i++) begin
      if (!hold_beat) begin
        if (sent < 16) rand32(); else v32 = 1'b0;
      end
      ordy32 = !(i >= 6 && i <= 9);
      #1;
      checks++; if (rdy32 !== ((occ < 4) || ordy32)) begin
        failures++; $display("FAIL bp_in_ready got=%b exp=%b occ=%0d", rdy32, (occ < 4) || ordy32, occ);
      end
      if (rdy32 === 1'b0) saw_full = 1'b1;
      if (stalled) begin
        checks++; if ({ov32, sum32, co32, of32} !== held) begin
          failures++; $display("FAIL bp_hold got=%h exp=%h", {ov32, sum32, co32, of32}, held);
        end
      end
      if (ov32 && ordy32) begin
        checks++;
        if (q32.size() == 0) begin failures++; $display("FAIL bp_spurious got=%h exp=none", sum32); end
        else begin
          e = q32.pop_front(); ntake++; occ--;
          if ({sum32, co32, of32} !== {e.sum, e.cout, e.ovf}) begin
            failures++; $display("FAIL bp_result got=%h c=%b o=%b exp=%h c=%b o=%b", sum32, co32, of32, e.sum, e.cout, e.ovf);
          end
        end
      end
      if (v32 && rdy32) begin e = model(32, a32, b32, cin32, sub32); e.acc = cyc; q32.push_back(e); sent++; occ++; end
      hold_beat = v32 && !rdy32;
      stalled   = ov32 && !ordy32;
      held      = {ov32, sum32, co32, of32};
      nxt();
    end
    v32 = 1'b0; ordy32 = 1'b1;
    checks++; if (!saw_full) begin failures++; $display("FAIL bp_full got=never_full exp=in_ready_low"); end
    checks++; if (ntake != 16 || q32.size() != 0) begin failures++; $display("FAIL bp_count got=%0d exp=16", ntake); end
  endtask

  task automatic test_reset_midflight();
    ordy32 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 2) rand32(); else v32 = 1'b0;
      #1;
      if (i == 5) begin
        checks++; if (ov32 !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b exp=1", ov32); end
      end
      if (i < 5) nxt();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({ov32, sum32, co32, of32} !== 35'd0) begin
      failures++; $display("FAIL rst_mid_outputs got=%h exp=0", {ov32, sum32, co32, of32});
    end
    checks++; if (rdy32 !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=1", rdy32); end
    @(negedge clk);
    rst_n = 1'b1; ordy32 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nxt();
      checks++; if (ov32 !== 1'b0) begin failures++; $display("FAIL rst_stale got=%b exp=0", ov32); end
    end
  endtask

  task automatic test_config_sweep();
    int   acc_n [2], take_n [2], wp [2], rp [2], min_lat [2], nseg_d [2];
    bit   hold [2];
    exp_t e;
    nseg_d[0] = 1; nseg_d[1] = 4;
    for (int d = 0; d < 2; d++) begin
      acc_n[d] = 0; take_n[d] = 0; wp[d] = 0; rp[d] = 0; min_lat[d] = 1000; hold[d] = 1'b0;
    end
    for (int c = 0; c < 60000 && (take_n[0] < 10000 || take_n[1] < 10000); c++) begin
      for (int d = 0; d < 2; d++) begin
        if (!hold[d]) begin
          if (acc_n[d] < 10000 && $urandom_range(0, 3) != 0) begin
            v16[d] = 1'b1; a16[d] = 16'($urandom); b16[d] = 16'($urandom);
            cin16[d] = 1'($urandom); sub16[d] = 1'($urandom);
          end else v16[d] = 1'b0;
        end
        ordy16[d] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++; if (rdy16[d] !== ((wp[d] - rp[d] < nseg_d[d]) || ordy16[d])) begin
          failures++; $display("FAIL sweep%0d_in_ready got=%b occ=%0d", d, rdy16[d], wp[d] - rp[d]);
        end
        if (ov16[d] && ordy16[d]) begin
          checks++;
          if (rp[d] == wp[d]) begin failures++; $display("FAIL sweep%0d_spurious got=%h exp=none", d, sum16[d]); end
          else begin
            e = buf16[d][rp[d] % 64]; rp[d]++; take_n[d]++;
            if (cyc - e.acc < min_lat[d]) min_lat[d] = cyc - e.acc;
            if ({sum16[d], co16[d], of16[d]} !== {e.sum[15:0], e.cout, e.ovf}) begin
              failures++; $display("FAIL sweep%0d_result got=%h c=%b o=%b exp=%h c=%b o=%b",
                                   d, sum16[d], co16[d], of16[d], e.sum[15:0], e.cout, e.ovf);
            end
          end
        end
        if (v16[d] && rdy16[d]) begin
          e = model(16, {16'd0, a16[d]}, {16'd0, b16[d]}, cin16[d], sub16[d]);
          e.acc = cyc; buf16[d][wp[d] % 64] = e; wp[d]++; acc_n[d]++;
        end
        hold[d] = v16[d] && !rdy16[d];
      end
      nxt();
    end
    for (int d = 0; d < 2; d++) begin
      v16[d] = 1'b0;
      checks++; if (take_n[d] != 10000 || rp[d] != wp[d]) begin
        failures++; $display("FAIL sweep%0d_count got=%0d exp=10000", d, take_n[d]);
      end
      checks++; if (min_lat[d] != nseg_d[d]) begin
        failures++; $display("FAIL sweep%0d_latency got=%0d exp=%0d", d, min_lat[d], nseg_d[d]);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; rst_n = 1'b0;
    v32 = 1'b0; a32 = 32'd0; b32 = 32'd0; cin32 = 1'b0; sub32 = 1'b0; ordy32 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      v16[d] = 1'b0; a16[d] = 16'd0; b16[d] = 16'd0; cin16[d] = 1'b0; sub16[d] = 1'b0; ordy16[d] = 1'b0;
    end
    test_reset();
    test_carry_chain();
    test_back_to_back();
    test_streaming();
    test_backpressure();
    test_reset_midflight();
    test_config_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
